// File: rtl/serial_operand_tx.sv
// serial_operand_tx: parallel-to-serial feeder for the bit-serial adder.
// Shifts a pair of WIDTH-bit operands out LSB first in lockstep, followed
// by PAD zero bits, with first/last frame markers on every frame.
module serial_operand_tx #(
   parameter int WIDTH = 8,
   parameter int PAD   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out1,
   output logic             out2,
   output logic             out_valid,
   output logic             out_first,
   output logic             out_last,
   output logic             busy
);

   localparam int L  = WIDTH + PAD;
   localparam int CW = (L > 1) ? $clog2(L) : 1;
   // Counter value on the cycle before the last bit; only meaningful when L >= 2.
   localparam logic [CW-1:0] PRE_LAST = CW'((L >= 2) ? (L - 2) : 0);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [L-1:0]  sh_a;
   logic [L-1:0]  sh_b;
   logic          accept;

   // Ready while idle, or on the final bit so the next frame follows with no bubble.
   assign in_ready = (state == IDLE) | ((state == SHIFT) & out_last);
   assign accept   = in_valid & in_ready;

   // The current frame bit is always bit 0 of each shift register.
   assign out1 = sh_a[0];
   assign out2 = sh_b[0];
   assign busy = out_valid;

   // Frame sequencer: load on accept, shift while mid-frame, drop to idle after the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sh_a      <= '0;
         sh_b      <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept) begin
         // Zero-extension above the MSB supplies the PAD bits.
         state     <= SHIFT;
         cnt       <= '0;
         sh_a      <= L'(a);
         sh_b      <= L'(b);
         out_valid <= 1'b1;
         out_first <= 1'b1;
         out_last  <= (L == 1);
      end else if ((state == SHIFT) && !out_last) begin
         cnt       <= cnt + CW'(1);
         sh_a      <= sh_a >> 1;
         sh_b      <= sh_b >> 1;
         out_first <= 1'b0;
         out_last  <= (cnt == PRE_LAST);
      end else if (state == SHIFT) begin
         // Last bit shown with nothing queued behind it.
         state     <= IDLE;
         cnt       <= '0;
         sh_a      <= '0;
         sh_b      <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_operand_tx.sv
// Bench for serial_operand_tx: one WIDTH=8/PAD=1 instance and one WIDTH=1/PAD=0
// instance, each compared every cycle against a queue of expected frame bits.
module tb_serial_operand_tx;

   typedef struct packed {
      logic o1;
      logic o2;
      logic f;
      logic l;
   } fbit_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       v8, v1;
   logic [7:0] a8, b8;
   logic [0:0] a1, b1;

   logic rdy8, o1_8, o2_8, ov8, of8, ol8, bz8;
   logic rdy1, o1_1, o2_1, ov1, of1, ol1, bz1;

   fbit_t q8[$];
   fbit_t q1[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_operand_tx #(.WIDTH(8), .PAD(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
      .out1(o1_8), .out2(o2_8), .out_valid(ov8), .out_first(of8), .out_last(ol8), .busy(bz8)
   );

   serial_operand_tx #(.WIDTH(1), .PAD(0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .a(a1), .b(b1),
      .out1(o1_1), .out2(o2_1), .out_valid(ov1), .out_first(of1), .out_last(ol1), .busy(bz1)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // An accepted pair becomes a whole frame: operand bits LSB first, then zeros.
   task automatic push_frame8(input logic [7:0] pa, input logic [7:0] pb);
      for (int i = 0; i < 9; i++)
         q8.push_back('{o1: (i < 8) ? pa[i] : 1'b0, o2: (i < 8) ? pb[i] : 1'b0,
                         f: (i == 0), l: (i == 8)});
   endtask

   task automatic check_outputs();
      fbit_t e8, e1;
      e8 = (q8.size() != 0) ? q8[0] : '0;
      e1 = (q1.size() != 0) ? q1[0] : '0;
      chk("w8_out_valid", 16'(ov8), 16'(q8.size() != 0));
      chk("w8_busy",      16'(bz8), 16'(q8.size() != 0));
      chk("w8_out1",      16'(o1_8), 16'(e8.o1));
      chk("w8_out2",      16'(o2_8), 16'(e8.o2));
      chk("w8_first",     16'(of8), 16'(e8.f));
      chk("w8_last",      16'(ol8), 16'(e8.l));
      chk("w1_out_valid", 16'(ov1), 16'(q1.size() != 0));
      chk("w1_busy",      16'(bz1), 16'(q1.size() != 0));
      chk("w1_out1",      16'(o1_1), 16'(e1.o1));
      chk("w1_out2",      16'(o2_1), 16'(e1.o2));
      chk("w1_first",     16'(of1), 16'(e1.f));
      chk("w1_last",      16'(ol1), 16'(e1.l));
   endtask

   // One clock: check readiness, apply the edge to the model, then check outputs.
   task automatic step();
      logic r8, r1, acc8, acc1;
      logic [7:0] sa8, sb8;
      logic       sa1, sb1;
      // Ready exactly when nothing, or only the final bit of a frame, remains.
      r8 = (q8.size() <= 1);
      r1 = (q1.size() <= 1);
      chk("w8_in_ready", 16'(rdy8), 16'(r8));
      chk("w1_in_ready", 16'(rdy1), 16'(r1));
      acc8 = !rst && v8 && r8;
      acc1 = !rst && v1 && r1;
      sa8 = a8; sb8 = b8; sa1 = a1[0]; sb1 = b1[0];
      @(posedge clk);
      if (rst) begin
         q8.delete();
         q1.delete();
      end else begin
         if (q8.size() != 0) void'(q8.pop_front());
         if (q1.size() != 0) void'(q1.pop_front());
         if (acc8) push_frame8(sa8, sb8);
         if (acc1) q1.push_back('{o1: sa1, o2: sb1, f: 1'b1, l: 1'b1});
      end
      #1;
      check_outputs();
   endtask

   initial begin
      logic [8:0] s1, s2, sum;
      logic       c;
      rst = 1'b1; v8 = 1'b0; v1 = 1'b0; a8 = '0; b8 = '0; a1 = '0; b1 = '0;
      step();
      step();
      rst = 1'b0;
      step();
      chk("reset_in_ready", 16'(rdy8), 16'd1);

      // Single frame 0x0B / 0x0F, recorded and summed serially as the adder would.
      v8 = 1'b1; a8 = 8'h0B; b8 = 8'h0F;
      step();
      v8 = 1'b0; a8 = '0; b8 = '0;
      s1 = '0; s2 = '0; sum = '0; c = 1'b0;
      for (int i = 0; i < 9; i++) begin
         s1[i] = o1_8;
         s2[i] = o2_8;
         sum[i] = o1_8 ^ o2_8 ^ c;
         c = (o1_8 & o2_8) | (o1_8 & c) | (o2_8 & c);
         if (i < 8) step();
      end
      chk("t1_stream1", 16'(s1), 16'h00B);
      chk("t1_stream2", 16'(s2), 16'h00F);
      chk("t1_sum", 16'(sum), 16'h01A);
      step();
      step();

      // Back-to-back frames with in_valid held high.
      v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
      step();
      a8 = 8'h00; b8 = 8'h00;
      for (int i = 0; i < 9; i++) step();
      chk("t2_first_after_last", 16'(of8), 16'd1);
      v8 = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // in_valid mid-frame is ignored.
      v8 = 1'b1; a8 = 8'h5C; b8 = 8'hA3;
      step();
      v8 = 1'b0;
      for (int i = 0; i < 3; i++) step();
      v8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
      chk("t3_ready_mid", 16'(rdy8), 16'd0);
      step();
      v8 = 1'b0;
      for (int i = 0; i < 7; i++) step();

      // Reset at bit 4 aborts the frame; a new frame then starts cleanly.
      v8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      step();
      v8 = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_ready_after_rst", 16'(rdy8), 16'd1);
      chk("t4_valid_after_rst", 16'(ov8), 16'd0);
      v8 = 1'b1; a8 = 8'h33; b8 = 8'hC3;
      step();
      v8 = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Reset wins over a simultaneous request from idle.
      rst = 1'b1; v8 = 1'b1; v1 = 1'b1; a1 = 1'b1;
      step();
      rst = 1'b0; v8 = 1'b0; v1 = 1'b0;
      step();
      chk("t5_no_frame", 16'(ov8), 16'd0);
      step();

      // Single-bit frames back to back.
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("t6_first_last", 16'({of1, ol1, o1_1, o2_1}), 16'b1110);
      v1 = 1'b0;
      step();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         v8  = $urandom_range(0, 3) != 0;
         v1  = $urandom_range(0, 1) != 0;
         a8  = 8'($urandom);
         b8  = 8'($urandom);
         a1  = 1'($urandom);
         b1  = 1'($urandom);
         step();
      end
      rst = 1'b0; v8 = 1'b0; v1 = 1'b0;
      for (int i = 0; i < 12; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
